// File: rtl/candidate_generator.sv
// candidate_generator
//   Enumerates alphanumeric candidate strings with a base-62 counter of
//   NUM_CHARS digits. Each candidate is packed into a zero-padded 1024-bit
//   message block that feeds the hash input register. One candidate is
//   written per cycle while the hash core is ready.
//
// Ports
//   clk_i    : clock, all state on rising edge
//   rst_n_i  : asynchronous active-low reset
//   start_i  : load seed and begin enumeration (from IDLE or DONE)
//   stop_i   : abort enumeration, return to IDLE (wins over start_i)
//   seed_i   : starting digits, digit i at [6i+5:6i], digit 0 least significant
//   ready_i  : hash core can accept a block this cycle
//   write_o  : write strobe to input register
//   zero_o   : clear strobe to input register (the single CLEAR cycle)
//   state_o  : candidate message block, byte 0 = most significant character
//   busy_o   : enumeration in progress (CLEAR or RUN)
//   done_o   : full keyspace exhausted
//   count_o  : candidates written since last start
module candidate_generator #(
    parameter int NUM_CHARS = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   start_i,
    input  logic                   stop_i,
    input  logic [6*NUM_CHARS-1:0] seed_i,
    input  logic                   ready_i,
    output logic                   write_o,
    output logic                   zero_o,
    output logic [1023:0]          state_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [47:0]            count_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t      r_state;
    logic [5:0]  r_digit [NUM_CHARS];
    logic [47:0] r_count;

    logic [5:0]  w_seed_digit [NUM_CHARS];
    logic [5:0]  w_inc_digit  [NUM_CHARS];
    logic        w_carry_out;
    logic        w_write;

    // Map a base-62 digit onto its ASCII character: 0-9, A-Z, a-z.
    function automatic logic [7:0] digit_to_ascii(input logic [5:0] d);
        logic [7:0] w_d;
        w_d = {2'b00, d};
        if (d < 6'd10)
            return w_d + 8'h30;
        else if (d < 6'd36)
            return w_d + 8'h37;
        else
            return w_d + 8'h3D;
    endfunction

    // Out-of-range seed digits (62, 63) are forced to 0.
    generate
        for (genvar gi = 0; gi < NUM_CHARS; gi++) begin : g_seed
            assign w_seed_digit[gi] = (seed_i[6*gi +: 6] > 6'd61) ? 6'd0 : seed_i[6*gi +: 6];
        end
    endgenerate

    // Full ripple-carry increment; carry out of the MSD marks keyspace exhaustion
    // and leaves the digits all zero.
    always_comb begin
        logic c;
        c = 1'b1;
        for (int i = 0; i < NUM_CHARS; i++) begin
            w_inc_digit[i] = r_digit[i];
            if (c) begin
                if (r_digit[i] == 6'd61) begin
                    w_inc_digit[i] = 6'd0;
                end else begin
                    w_inc_digit[i] = r_digit[i] + 6'd1;
                    c              = 1'b0;
                end
            end
        end
        w_carry_out = c;
    end

    // Message block is a pure function of the registered digits.
    always_comb begin
        state_o = '0;
        for (int i = 0; i < NUM_CHARS; i++) begin
            state_o[8*(NUM_CHARS-1-i) +: 8] = digit_to_ascii(r_digit[i]);
        end
    end

    assign w_write = (r_state == ST_RUN) && ready_i && !stop_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            for (int i = 0; i < NUM_CHARS; i++) begin
                r_digit[i] <= 6'd0;
            end
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (stop_i) begin
                        r_state <= ST_IDLE;
                    end else if (start_i) begin
                        r_state <= ST_CLEAR;
                        r_count <= '0;
                        for (int i = 0; i < NUM_CHARS; i++) begin
                            r_digit[i] <= w_seed_digit[i];
                        end
                    end
                end
                ST_CLEAR: begin
                    r_state <= stop_i ? ST_IDLE : ST_RUN;
                end
                ST_RUN: begin
                    if (stop_i) begin
                        // Digits and count stay put so the last position can be read.
                        r_state <= ST_IDLE;
                    end else if (ready_i) begin
                        r_count <= r_count + 48'd1;
                        for (int i = 0; i < NUM_CHARS; i++) begin
                            r_digit[i] <= w_inc_digit[i];
                        end
                        if (w_carry_out) begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign write_o = w_write;
    assign zero_o  = (r_state == ST_CLEAR);
    assign busy_o  = (r_state == ST_CLEAR) || (r_state == ST_RUN);
    assign done_o  = (r_state == ST_DONE);
    assign count_o = r_count;

endmodule

// File: doc/candidate_generator.md
Name: candidate_generator

Overview:
- Upstream feeder for the 1024-bit input state register. It enumerates alphanumeric candidate strings with a base-62 counter of NUM_CHARS digits.
- Each candidate is packed into a zero-padded 1024-bit message block. The block drives the register's write and zero strobes, at one candidate per cycle while the hash core is ready.

Parameters:
- NUM_CHARS, 8, number of characters per candidate (legal 1..16); bytes NUM_CHARS..127 of the block are always zero.

Ports:
- clk_i  input  1  clock, all state on rising edge
- rst_n_i  input  1  reset, asynchronous, active-low
- start_i  input  1  load seed and begin enumeration
- stop_i  input  1  abort enumeration, return to idle
- seed_i  input  6*NUM_CHARS  starting digit values, digit i at [6i+5:6i], digit 0 least significant
- ready_i  input  1  hash core can accept a block this cycle
- write_o  output  1  write strobe to input register
- zero_o  output  1  clear strobe to input register
- state_o  output  1024  candidate message block
- busy_o  output  1  enumeration in progress (CLEAR or RUN)
- done_o  output  1  full keyspace exhausted
- count_o  output  48  candidates written since last start

Behaviour:
- Reset (async, rst_n_i=0): FSM to IDLE, all digits 0, count_o=0. write_o, zero_o, busy_o and done_o are 0.
- state_o during reset is "000…0" packed per the rules below. It is not all-zero unless NUM_CHARS rules give that.
- Digit-to-ASCII mapping:
  - 0–9 map to 0x30–0x39.
  - 10–35 map to 0x41–0x5A.
  - 36–61 map to 0x61–0x7A.
- Seed digits ≥62 load as 0.
- Packing:
  - Byte k occupies state_o[8k+7:8k].
  - Digit i occupies byte NUM_CHARS-1-i, so byte 0 holds the most significant character.
  - All higher bytes are 0.
  - state_o is a pure function of the registered digits. It has no other pipeline stage.
- FSM states: IDLE, CLEAR, RUN, DONE.
- IDLE:
  - start_i=1 and stop_i=0: load digits from seed_i, clear count_o to 0, go to CLEAR.
  - stop_i always wins over start_i.
- CLEAR:
  - zero_o=1 for exactly this one cycle, then go to RUN.
  - stop_i in CLEAR: go to IDLE, with zero_o still asserted that cycle.
- RUN:
  - write_o = ready_i & ~stop_i (combinational).
  - On a write cycle:
    - count_o increments, wrapping mod 2^48.
    - Digits increment by 1 with full ripple carry; digit value 61 wraps to 0 with carry.
    - If every digit was 61 (carry out of the MSD), digits become all 0 and the FSM goes to DONE.
  - ready_i=0: no write. Digits, state_o and count_o are held. No timeout.
  - stop_i=1: no write that cycle, go to IDLE. Digits and count_o are held for inspection.
- DONE:
  - done_o=1, busy_o=0, write_o=0.
  - start_i reloads the seed and enters CLEAR, exactly as from IDLE, and clears done_o. stop_i returns to IDLE.
- Flag outputs:
  - busy_o=1 in CLEAR and RUN.
  - done_o is registered, high only in DONE.
- start_i during CLEAR or RUN is ignored.
- Throughput: 1 candidate per cycle with ready_i held high.
- Latency: start_i to first write_o is 2 cycles (CLEAR, then the first RUN cycle).
- Async reset mid-RUN aborts immediately, with no partial write after reset deasserts.
- The block never asserts zero_o and write_o in the same cycle.

Test Plan:
- Reset: hold rst_n_i=0 with NUM_CHARS=4 -> write_o=zero_o=busy_o=done_o=0, count_o=0, state_o[31:0]=0x30303030, state_o[1023:32]=0.
- Basic run: NUM_CHARS=4, seed all 0, start_i pulse, ready_i=1 -> zero_o high on cycle 1, write_o high from cycle 2. Required state_o[31:0] values:
  - first write: 0x30303030 ("0000")
  - second write: 0x31303030 ("0001")
  - 11th write: 0x41303030 ("000A")
  - count_o=11 after the 11th write.
- Carry ripple: NUM_CHARS=4, seed digits {0,0,61,61} ("00zz") -> first write 0x7A7A3030, second write 0x30303130 ("0100").
- Backpressure: in RUN, drop ready_i for 5 cycles -> write_o=0, state_o and count_o frozen. Raise ready_i -> write resumes with the held candidate.
- Keyspace wrap: NUM_CHARS=2, seed "zz" -> exactly one write of state_o[15:0]=0x7A7A, then done_o=1, busy_o=0, count_o=1, state_o[15:0]=0x3030. A second start_i restarts cleanly.
- Stop/reset priority:
  - start_i and stop_i together in IDLE -> stays IDLE.
  - stop_i with ready_i=1 in RUN -> no write, IDLE next cycle.
  - rst_n_i low mid-RUN -> IDLE immediately, count_o=0.
